// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: CRC-32 constants, the fcs_tx state encoding and
// the per-dibit CRC next-state function (also used by the receive-side cksum).
package eth_pkg;

    localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam int          FCS_DIBITS = 16;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAD,
        FCS,
        IFG
    } fcs_tx_state_t;

    // Non-reflected, MSB-first: d[1] is earlier on the wire, so it shifts in first.
    function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 1; i >= 0; i--) begin
            if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
            else              c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_dibit_step.sv
// Combinational one-dibit CRC-32 step; shared between fcs_tx and cksum.
module crc32_dibit_step
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [1:0]  d,
    output logic [31:0] crc_next
);

    assign crc_next = crc32_dibit(crc, d);

endmodule

// File: rtl/fcs_tx.sv
// Transmit FCS inserter: passes a dibit frame through, zero-pads it to the
// minimum length, appends ~CRC-32 MSB dibit first and then holds the IFG.
module fcs_tx
    import eth_pkg::*;
#(
    parameter int IFG_DIBITS = 48,
    parameter int PAD_EN     = 1,
    parameter int MIN_DIBITS = 240
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       axiir,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       err
);

    localparam int              CW       = $clog2(MIN_DIBITS + 1);
    localparam int              GW       = $clog2(IFG_DIBITS + 1);
    localparam logic [CW-1:0]   CNT_MIN  = CW'(MIN_DIBITS);
    localparam logic [GW-1:0]   GAP_LAST = GW'(IFG_DIBITS - 1);
    localparam logic [3:0]      FCS_LAST = 4'(FCS_DIBITS - 1);

    fcs_tx_state_t   state;
    logic [31:0]     crc;
    logic [31:0]     crc_step;
    logic [31:0]     fcs_sr;
    logic [CW-1:0]   cnt;
    logic [GW-1:0]   gap;
    logic [3:0]      idx;
    logic [1:0]      step_d;
    logic            pad_now;
    logic            in_frame;

    assign in_frame = (state == IDLE) || (state == DATA);
    assign pad_now  = (PAD_EN != 0) && (cnt < CNT_MIN);

    // The DATA->PAD transition already emits the first zero pad dibit.
    assign step_d = ((state == PAD) || ((state == DATA) && !axiiv)) ? 2'b00 : axiid;

    crc32_dibit_step u_step (
        .crc      (crc),
        .d        (step_d),
        .crc_next (crc_step)
    );

    // NOTE: non-blocking throughout, so every branch reads the pre-edge crc/cnt values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            crc    <= CRC_INIT;
            cnt    <= '0;
            gap    <= '0;
            idx    <= '0;
            fcs_sr <= '0;
            axiov  <= 1'b0;
            axiod  <= 2'b00;
            axiir  <= 1'b1;
            err    <= 1'b0;
        end else begin
            err <= axiiv && !in_frame;
            case (state)
                IDLE: begin
                    axiov <= axiiv;
                    axiod <= axiiv ? axiid : 2'b00;
                    if (axiiv) begin
                        crc   <= crc_step;
                        cnt   <= CW'(1);
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (axiiv) begin
                        axiov <= 1'b1;
                        axiod <= axiid;
                        crc   <= crc_step;
                        if (cnt != CNT_MIN) cnt <= cnt + CW'(1);
                    end else if (pad_now) begin
                        axiov <= 1'b1;
                        axiod <= 2'b00;
                        crc   <= crc_step;
                        cnt   <= cnt + CW'(1);
                        axiir <= 1'b0;
                        state <= PAD;
                    end else begin
                        axiov  <= 1'b1;
                        axiod  <= ~crc[31:30];
                        fcs_sr <= {~crc[29:0], 2'b00};
                        idx    <= '0;
                        axiir  <= 1'b0;
                        state  <= FCS;
                    end
                end
                PAD: begin
                    if (cnt == CNT_MIN) begin
                        axiod  <= ~crc[31:30];
                        fcs_sr <= {~crc[29:0], 2'b00};
                        idx    <= '0;
                        state  <= FCS;
                    end else begin
                        axiod <= 2'b00;
                        crc   <= crc_step;
                        cnt   <= cnt + CW'(1);
                    end
                end
                FCS: begin
                    if (idx == FCS_LAST) begin
                        axiov <= 1'b0;
                        axiod <= 2'b00;
                        gap   <= '0;
                        state <= IFG;
                    end else begin
                        axiod  <= fcs_sr[31:30];
                        fcs_sr <= {fcs_sr[29:0], 2'b00};
                        idx    <= idx + 4'd1;
                    end
                end
                IFG: begin
                    if (gap == GAP_LAST) begin
                        crc   <= CRC_INIT;
                        cnt   <= '0;
                        axiir <= 1'b1;
                        state <= IDLE;
                    end else begin
                        gap <= gap + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fcs_tx.md
Name: fcs_tx

Overview:
- Transmit-side counterpart of the RMII receive checksum block (cksum).
- Accepts a frame as a 2-bit dibit stream (MAC header + payload, no preamble).
- Optionally zero-pads the frame to the Ethernet minimum, appends the 32-bit CRC-32 FCS, then enforces the inter-frame gap.
- Sits between the frame builder and the preamble/RMII output stage. Its output, fed to cksum, must produce done=1, kill=0.

Parameters:
IFG_DIBITS, 48, idle cycles after the last FCS dibit (96 bit times).
PAD_EN, 1, when 1, frames shorter than MIN_DIBITS are zero-padded before the FCS.
MIN_DIBITS, 240, minimum pre-FCS length in dibits (60 bytes).

Ports:
clk  input  1  system clock, 50 MHz.
rst_n  input  1  asynchronous, active-low reset.
axiiv  input  1  input dibit valid; a frame is one contiguous high run.
axiid  input  2  input dibit; bit 1 is earlier on the wire.
axiir  output  1  ready; high only in IDLE and DATA.
axiov  output  1  output dibit valid.
axiod  output  2  output dibit.
err  output  1  one-cycle pulse when axiiv=1 while axiir=0.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state IDLE, crc=32'hFFFF_FFFF, all counters 0.
  - axiov=0, axiod=2'b00, err=0, axiir=1.
  - Reset mid-frame abandons the frame; no partial FCS is emitted.
- CRC arithmetic:
  - Polynomial 32'h04C1_1DB7, non-reflected, MSB-first shift, init 32'hFFFF_FFFF.
  - Per dibit, process axiid[1] then axiid[0].
  - Transmitted FCS = ~crc, sent MSB dibit first (fcs[31:30] ... fcs[1:0]). This matches cksum's ordering.
- All outputs are registered. Data latency from input to output is 1 cycle.
- IDLE:
  - On axiiv=1: register the dibit to the output, update crc, set cnt=1, go to DATA.
- DATA:
  - axiiv=1: pass the dibit, update crc, cnt++ (saturating at MIN_DIBITS).
  - axiiv=0 (end of frame): if PAD_EN and cnt<MIN_DIBITS, go to PAD; else go to FCS.
  - The first PAD or FCS dibit appears in the cycle directly after the last data dibit on the output. There is no bubble on axiov.
- PAD:
  - Emit 2'b00 with axiov=1, update crc, cnt++.
  - When cnt reaches MIN_DIBITS, go to FCS.
- FCS:
  - Latch ~crc on entry. Emit 16 dibits with axiov=1.
  - After the 16th, axiov=0 and go to IFG.
- IFG:
  - axiov=0 for IFG_DIBITS cycles, then reset crc to init, clear cnt, go to IDLE.
  - axiir rises in the cycle the IDLE state is entered.
- axiir=0 in PAD, FCS and IFG. Any axiiv=1 in those states is dropped: no crc update, no output, err pulses for that cycle.
- Frame of exactly MIN_DIBITS: no padding. Frame longer than MIN_DIBITS: no padding, cnt saturates.
- axiod is 2'b00 whenever axiov=0.

Decomposition:
- Shared package eth_pkg holds:
  - CRC_POLY, CRC_INIT, FCS_DIBITS=16.
  - The state enum fcs_tx_state_t {IDLE, DATA, PAD, FCS, IFG}.
  - The crc32_dibit next-state function, shared with cksum.
- One sub-module, crc32_dibit_step: combinational, inputs crc[31:0] and d[1:0], output next crc[31:0].
  - cksum reuses this sub-module.

Test Plan:
1. PAD_EN=0, single dibit 2'b10 -> 1 data dibit, then 16 contiguous FCS dibits, then axiov=0 for 48 cycles. axiir is low for exactly 64 cycles starting the cycle after axiiv falls.
2. PAD_EN=0, 84-dibit message 168'h4261_7272_7921_2042_7265_616b_6661_7374_2074_696d65 sent MSB dibit first -> data echoed with 1-cycle latency, then FCS dibits spelling 32'h1a3a_ccb2: 00,01,10,10,00,11,10,10,11,00,11,00,10,11,00,10.
3. Loopback of output into cksum, for case 2 and a 300-dibit random frame -> cksum done=1, kill=0 on each. Flipping one data dibit in the loopback -> kill=1.
4. PAD_EN=1, 10-dibit frame -> 10 data dibits, 230 2'b00 pad dibits, 16 FCS dibits. Total 256 contiguous axiov cycles; loopback check passes.
5. axiiv held high for 5 cycles during FCS -> err pulses 5 times, output FCS unchanged. The next frame, sent after axiir=1, has a correct FCS.
6. rst_n asserted at FCS dibit 7 -> axiov drops to 0 asynchronously, axiir=1. The next frame's FCS is computed from init, verified by loopback.
